// File: rtl/vga_sync_receiver.sv
// -----------------------------------------------------------------------------
// vga_sync_receiver
//   Receiving end of the VGA timing interface. Samples the sync/blank pins
//   driven by a VGA controller, recovers the active pixel coordinates and
//   measures the raster against the nominal timing, reporting lock and
//   sticky error flags.
//
// Ports
//   Clk          in   pixel clock, all logic on the rising edge
//   Reset_n      in   asynchronous active-low reset
//   VGA_HS       in   horizontal sync, active low
//   VGA_VS       in   vertical sync, active low
//   VGA_BLANK_N  in   high during active pixels
//   clr_err      in   synchronous clear of err_flags
//   locked       out  raster matched the timing for LOCK_FRAMES frames
//   frame_start  out  1-cycle pulse on VS fall while locked
//   pix_valid    out  RxX/RxY describe the current active pixel
//   RxX          out  active pixel index within the line
//   RxY          out  active line index within the frame
//   err_flags    out  sticky: [0] H period, [1] HS/VS width,
//                     [2] active width/height, [3] V period / no signal
// -----------------------------------------------------------------------------
module vga_sync_receiver #(
   parameter int H_TOTAL     = 800,
   parameter int H_ACTIVE    = 640,
   parameter int H_SYNC      = 96,
   parameter int V_TOTAL     = 525,
   parameter int V_ACTIVE    = 480,
   parameter int V_SYNC      = 2,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       VGA_HS,
   input  logic       VGA_VS,
   input  logic       VGA_BLANK_N,
   input  logic       clr_err,
   output logic       locked,
   output logic       frame_start,
   output logic       pix_valid,
   output logic [9:0] RxX,
   output logic [9:0] RxY,
   output logic [3:0] err_flags
);

   // hcnt reads one less than the elapsed cycles (it is 0 the cycle after a
   // fall), so period and HS-width checks compare against N-1.
   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] HS_LAST   = 10'(H_SYNC - 1);
   localparam logic [9:0] X_END     = 10'(H_ACTIVE);
   localparam logic [9:0] Y_END     = 10'(V_ACTIVE);
   localparam logic [9:0] V_LINES   = 10'(V_TOTAL);
   localparam logic [9:0] VS_LINES  = 10'(V_SYNC);
   localparam logic [9:0] CNT_MAX   = 10'd1023;
   localparam logic [9:0] NOSIG_AT  = 10'd1022;
   localparam logic [7:0] GOOD_LOCK = 8'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

   state_t     state_reg, state_next;
   logic       hs_q_reg, vs_q_reg, bl_q_reg;
   logic       hs_d_reg, vs_d_reg, bl_d_reg;
   logic [9:0] hcnt_reg, hcnt_next;
   logic [9:0] xcnt_reg, xcnt_next;
   logic [9:0] ycnt_reg, ycnt_next;
   logic [9:0] vlines_reg, vlines_next;
   logic [9:0] vs_low_reg, vs_low_next;
   logic       h_ref_reg, h_ref_next;
   logic       v_ref_reg, v_ref_next;
   logic       frame_err_reg, frame_err_next;
   logic [7:0] good_reg, good_next;
   logic       locked_reg, frame_start_reg, pix_valid_reg;
   logic [9:0] rxx_reg, rxy_reg;

   logic       hs_fall, hs_rise, vs_fall, vs_rise, bl_fall;
   logic       nosig, frame_bad, lock_next;
   logic [9:0] lines_seen, ycnt_seen;
   logic [3:0] err_new;

   // Two register stages: the first is the sampled pin, the second the
   // previous sample used for edge detection. Idle syncs load as 1.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hs_q_reg <= 1'b1;
         vs_q_reg <= 1'b1;
         bl_q_reg <= 1'b1;
         hs_d_reg <= 1'b1;
         vs_d_reg <= 1'b1;
         bl_d_reg <= 1'b1;
      end else begin
         hs_q_reg <= VGA_HS;
         vs_q_reg <= VGA_VS;
         bl_q_reg <= VGA_BLANK_N;
         hs_d_reg <= hs_q_reg;
         vs_d_reg <= vs_q_reg;
         bl_d_reg <= bl_q_reg;
      end
   end

   assign hs_fall = hs_d_reg & ~hs_q_reg;
   assign hs_rise = ~hs_d_reg & hs_q_reg;
   assign vs_fall = vs_d_reg & ~vs_q_reg;
   assign vs_rise = ~vs_d_reg & vs_q_reg;
   assign bl_fall = bl_d_reg & ~bl_q_reg;

   // One-shot on the cycle hcnt would step onto its saturation value.
   assign nosig = (hcnt_reg == NOSIG_AT) & ~hs_fall;

   // An HS fall coincident with the VS fall belongs to the ending frame, and
   // a coincident BLANK_N fall closes the frame's last active line.
   assign lines_seen = vlines_reg + {9'd0, hs_fall};
   assign ycnt_seen  = ycnt_reg + {9'd0, bl_fall};

   // h_ref/v_ref mark that a reference edge has been seen, so the first
   // measurement after reset or loss of signal is not judged.
   assign err_new[0] = hs_fall & h_ref_reg & (hcnt_reg != H_LAST);
   assign err_new[1] = (hs_rise & h_ref_reg & (hcnt_reg != HS_LAST)) |
                       (vs_rise & v_ref_reg & (vs_low_reg != VS_LINES));
   assign err_new[2] = (bl_fall & h_ref_reg & (xcnt_reg != X_END)) |
                       (vs_fall & v_ref_reg & (ycnt_seen != Y_END));
   assign err_new[3] = (vs_fall & v_ref_reg & (lines_seen != V_LINES)) | nosig;

   assign frame_bad = frame_err_reg | (|err_new);

   always_comb begin
      hcnt_next      = hcnt_reg;
      xcnt_next      = xcnt_reg;
      ycnt_next      = ycnt_reg;
      vlines_next    = vlines_reg;
      vs_low_next    = vs_low_reg;
      h_ref_next     = h_ref_reg;
      v_ref_next     = v_ref_reg;
      frame_err_next = frame_err_reg | (|err_new);

      if (hs_fall)
         hcnt_next = 10'd0;
      else if (hcnt_reg != CNT_MAX)
         hcnt_next = hcnt_reg + 10'd1;

      if (hs_fall)
         xcnt_next = 10'd0;
      else if (bl_q_reg && xcnt_reg != CNT_MAX)
         xcnt_next = xcnt_reg + 10'd1;

      if (vs_fall)
         ycnt_next = 10'd0;
      else if (bl_fall && ycnt_reg != CNT_MAX)
         ycnt_next = ycnt_reg + 10'd1;

      if (vs_fall)
         vlines_next = 10'd0;
      else if (hs_fall && vlines_reg != CNT_MAX)
         vlines_next = vlines_reg + 10'd1;

      // Lines with VS low, counting an HS fall that coincides with VS fall.
      if (vs_fall)
         vs_low_next = {9'd0, hs_fall};
      else if (hs_fall && !vs_q_reg && vs_low_reg != CNT_MAX)
         vs_low_next = vs_low_reg + 10'd1;

      if (hs_fall)
         h_ref_next = 1'b1;
      else if (nosig)
         h_ref_next = 1'b0;

      if (vs_fall)
         v_ref_next = 1'b1;
      else if (nosig)
         v_ref_next = 1'b0;

      // Errors on the VS-fall cycle are charged to the frame that just ended.
      if (vs_fall)
         frame_err_next = 1'b0;
   end

   always_comb begin
      state_next = state_reg;
      good_next  = good_reg;
      case (state_reg)
         SEARCH: begin
            if (vs_fall) begin
               state_next = ACQUIRE;
               good_next  = 8'd0;
            end
         end
         ACQUIRE: begin
            if (vs_fall) begin
               if (frame_bad) begin
                  good_next = 8'd0;
               end else begin
                  good_next = good_reg + 8'd1;
                  if (good_reg + 8'd1 >= GOOD_LOCK)
                     state_next = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (|err_new)
               state_next = SEARCH;
         end
         default: state_next = SEARCH;
      endcase
      if (nosig)
         state_next = SEARCH;
   end

   // Outputs follow the next state so they drop on the same edge the FSM
   // leaves LOCKED.
   assign lock_next = (state_next == LOCKED);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg       <= SEARCH;
         good_reg        <= 8'd0;
         hcnt_reg        <= 10'd0;
         xcnt_reg        <= 10'd0;
         ycnt_reg        <= 10'd0;
         vlines_reg      <= 10'd0;
         vs_low_reg      <= 10'd0;
         h_ref_reg       <= 1'b0;
         v_ref_reg       <= 1'b0;
         frame_err_reg   <= 1'b0;
         locked_reg      <= 1'b0;
         frame_start_reg <= 1'b0;
         pix_valid_reg   <= 1'b0;
         rxx_reg         <= 10'd0;
         rxy_reg         <= 10'd0;
      end else begin
         state_reg       <= state_next;
         good_reg        <= good_next;
         hcnt_reg        <= hcnt_next;
         xcnt_reg        <= xcnt_next;
         ycnt_reg        <= ycnt_next;
         vlines_reg      <= vlines_next;
         vs_low_reg      <= vs_low_next;
         h_ref_reg       <= h_ref_next;
         v_ref_reg       <= v_ref_next;
         frame_err_reg   <= frame_err_next;
         locked_reg      <= lock_next;
         frame_start_reg <= vs_fall & (state_reg == LOCKED) & lock_next;
         pix_valid_reg   <= bl_q_reg & lock_next;
         if (bl_q_reg && lock_next) begin
            rxx_reg <= xcnt_reg;
            rxy_reg <= ycnt_reg;
         end
      end
   end

   // Sticky error bits; a new error outranks a simultaneous clear.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_err
         logic flag_reg;
         always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n)
               flag_reg <= 1'b0;
            else if (err_new[gi])
               flag_reg <= 1'b1;
            else if (clr_err)
               flag_reg <= 1'b0;
         end
         assign err_flags[gi] = flag_reg;
      end
   endgenerate

   assign locked      = locked_reg;
   assign frame_start = frame_start_reg;
   assign pix_valid   = pix_valid_reg;
   assign RxX         = rxx_reg;
   assign RxY         = rxy_reg;

endmodule
